// File: rtl/uart_rx_peripheral.sv
// uart_rx_peripheral: memory-mapped 16x-oversampling UART receiver.
// Deframes 8-bit characters from rx into a receive FIFO. Exposes RXDATA,
// STATUS and BAUD_DIV through the slave's peripheral read/write port.
// Optional feature macro: UART_RX_PARITY_EN (8E1 frames with even-parity
// check). Without it, frames are 8N1 and STATUS[4] reads 0.
module uart_rx_peripheral #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 26
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_write,
  input  logic [3:0]            byte_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  data_valid,
  input  logic                  rx,
  output logic                  irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_WAIT   = 3'd5;

  // Address bits outside [3:2] and byte lanes 2-3 carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{write_addr[ADDR_WIDTH-1:4], write_addr[1:0],
                         read_addr[ADDR_WIDTH-1:4], read_addr[1:0],
                         write_data[DATA_WIDTH-1:16], byte_en[3:2]};

  // ---------------- register write decode ----------------
  logic        baud_wr, status_clr;
  logic [15:0] baud_div, new_div;

  assign baud_wr    = mem_write && (write_addr[3:2] == 2'd2) && (|byte_en[1:0]);
  assign status_clr = mem_write && (write_addr[3:2] == 2'd1) && byte_en[0];
  assign new_div    = {byte_en[1] ? write_data[15:8] : baud_div[15:8],
                       byte_en[0] ? write_data[7:0]  : baud_div[7:0]};

  // BAUD_DIV register, byte lanes 0-1 only
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          baud_div <= 16'(DEFAULT_DIV);
    else if (baud_wr) baud_div <= new_div;
  end

  // ---------------- rx synchronizer ----------------
  logic rx_meta, rx_sync;

  // Two-flop synchronizer; idle-high so reset to 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // ---------------- oversample tick generator ----------------
  logic [2:0]  state;
  logic [15:0] div_cnt;
  logic        tick, start_det;

  assign tick      = (div_cnt == 16'd0);
  assign start_det = (state == S_IDLE) && !rx_sync;

  // Down-counter: tick at zero, reload BAUD_DIV. Re-phased on a start edge
  // so sample points sit a fixed distance from the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   div_cnt <= 16'(DEFAULT_DIV);
    else if (baud_wr)          div_cnt <= new_div;
    else if (start_det || tick) div_cnt <= baud_div;
    else                       div_cnt <= div_cnt - 16'd1;
  end

  // ---------------- receive FSM ----------------
  logic [3:0] os_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       stop_smp, rx_push, frame_set, par_set;

  assign stop_smp  = (state == S_STOP) && tick && (os_cnt == 4'd15);
  assign frame_set = stop_smp && !rx_sync;

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  assign par_set = (state == S_PARITY) && tick && (os_cnt == 4'd15) &&
                   (rx_sync != ^shreg);
  assign rx_push = stop_smp && rx_sync && !par_bad;
`else
  assign par_set = 1'b0;
  assign rx_push = stop_smp && rx_sync;
`endif

  // Frame deserializer: start validation, 8 data bits LSB first, [parity], stop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      os_cnt  <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (!rx_sync) begin
          state  <= S_START;
          os_cnt <= '0;
        end
        S_START: if (tick) begin
          if (os_cnt == 4'd7) begin
            state   <= rx_sync ? S_IDLE : S_DATA;
            os_cnt  <= '0;
            bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
          end else begin
            os_cnt <= os_cnt + 4'd1;
          end
        end
        S_DATA: if (tick) begin
          os_cnt <= os_cnt + 4'd1;
          if (os_cnt == 4'd15) begin
            shreg   <= {rx_sync, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
`ifdef UART_RX_PARITY_EN
            if (bit_cnt == 3'd7) state <= S_PARITY;
`else
            if (bit_cnt == 3'd7) state <= S_STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: if (tick) begin
          os_cnt <= os_cnt + 4'd1;
          if (os_cnt == 4'd15) begin
            par_bad <= (rx_sync != ^shreg);
            state   <= S_STOP;
          end
        end
`endif
        S_STOP: if (tick) begin
          os_cnt <= os_cnt + 4'd1;
          if (os_cnt == 4'd15) state <= rx_sync ? S_IDLE : S_WAIT;
        end
        // Broken stop bit: hold off until the line returns idle
        S_WAIT: if (rx_sync) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---------------- receive FIFO ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          pop, do_push, ovr_set, full, not_empty;

  assign not_empty = (count != '0);
  assign full      = (count == FULL_CNT);
  assign pop       = read_en && (read_addr[3:2] == 2'd0) && not_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push   = rx_push && (!full || pop);
  assign ovr_set   = rx_push && full && !pop;

  // FIFO storage
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shreg;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------- sticky status flags ----------------
  logic overrun, frame_err, parity_err;

  // Sticky error flags; a set in the same cycle beats a W1C clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= ovr_set   | (overrun   & ~(status_clr & write_data[2]));
      frame_err <= frame_set | (frame_err & ~(status_clr & write_data[3]));
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity error flag, same set-wins W1C behaviour
  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= par_set | (parity_err & ~(status_clr & write_data[4]));
  end
`else
  logic unused_par;
  assign unused_par = par_set;
  assign parity_err = 1'b0;
`endif

  assign irq = not_empty | overrun | frame_err | parity_err;

  // ---------------- read path ----------------
  logic [DATA_WIDTH-1:0] status_w, rd_mux;

  // Read mux; RXDATA reads 0 when the FIFO is empty
  always_comb begin
    status_w          = '0;
    status_w[0]       = not_empty;
    status_w[1]       = full;
    status_w[2]       = overrun;
    status_w[3]       = frame_err;
    status_w[4]       = parity_err;
    status_w[8 +: CW] = count;
    rd_mux            = '0;
    case (read_addr[3:2])
      2'd0:    if (not_empty) rd_mux[7:0] = mem[rd_ptr];
      2'd1:    rd_mux = status_w;
      2'd2:    rd_mux[15:0] = baud_div;
      default: rd_mux = '0;
    endcase
  end

  // Registered read data with one-cycle valid strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data  <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= read_en;
      if (read_en) read_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_uart_rx_peripheral.sv
// Self-checking bench for uart_rx_peripheral: register table plus serial
// frame sequences, with a scoreboard queue of expected received bytes.
module tb_uart_rx_peripheral;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_write = 1'b0;
  logic [3:0]  byte_en = '0;
  logic [31:0] write_addr = '0;
  logic [31:0] write_data = '0;
  logic        read_en = 1'b0;
  logic [31:0] read_addr = '0;
  logic [31:0] read_data;
  logic        data_valid;
  logic        rx = 1'b1;
  logic        irq;

  uart_rx_peripheral #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .FIFO_DEPTH(DEPTH),
                       .DEFAULT_DIV(26)) dut (
    .clk(clk), .rst(rst), .mem_write(mem_write), .byte_en(byte_en),
    .write_addr(write_addr), .write_data(write_data), .read_en(read_en),
    .read_addr(read_addr), .read_data(read_data), .data_valid(data_valid),
    .rx(rx), .irq(irq));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    @(negedge clk);
    mem_write = 1'b1; write_addr = addr; write_data = data; byte_en = be;
    @(negedge clk);
    mem_write = 1'b0; byte_en = '0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    read_en = 1'b1; read_addr = addr;
    @(negedge clk);
    read_en = 1'b0;
    data = read_data;
    check("data_valid_hi", {31'd0, data_valid}, 32'd1);
    @(negedge clk);
    check("data_valid_lo", {31'd0, data_valid}, 32'd0);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(addr, d);
    check(name, d, exp);
  endtask

  // Pop RXDATA and compare against the scoreboard (0 when nothing expected)
  task automatic rd_rx(input string name);
    logic [31:0] d, exp;
    exp = (sb.size() != 0) ? {24'd0, sb.pop_front()} : 32'd0;
    bus_read(32'h0, d);
    check(name, d, exp);
  endtask

  task automatic hold_rx(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  // Serial frame; par_flip inverts the even-parity bit when parity is built in
  task automatic send_byte(input logic [7:0] b, input logic stop_bit,
                           input logic par_flip, input int bpb);
    @(negedge clk);
    hold_rx(1'b0, bpb);
    for (int i = 0; i < 8; i++) hold_rx(b[i], bpb);
`ifdef UART_RX_PARITY_EN
    hold_rx((^b) ^ par_flip, bpb);
`endif
    hold_rx(stop_bit, bpb);
    hold_rx(1'b1, 2 * bpb);
`ifdef UART_RX_PARITY_EN
    if (stop_bit && !par_flip && sb.size() < DEPTH) sb.push_back(b);
`else
    if (stop_bit && sb.size() < DEPTH) sb.push_back(b);
`endif
  endtask

  initial begin
    tbl[0]  = '{1'b0, 32'h8, 32'h0,        4'h0, 32'h0000001A, "baud_reset"};
    tbl[1]  = '{1'b0, 32'h4, 32'h0,        4'h0, 32'h00000000, "status_reset"};
    tbl[2]  = '{1'b0, 32'h0, 32'h0,        4'h0, 32'h00000000, "rxdata_empty"};
    tbl[3]  = '{1'b1, 32'h8, 32'h12345678, 4'h3, 32'h0,        "wr_baud_lo"};
    tbl[4]  = '{1'b0, 32'h8, 32'h0,        4'h0, 32'h00005678, "baud_lanes01"};
    tbl[5]  = '{1'b1, 32'h8, 32'hFFFFFFFF, 4'hC, 32'h0,        "wr_baud_hi"};
    tbl[6]  = '{1'b0, 32'h8, 32'h0,        4'h0, 32'h00005678, "baud_lanes23_ign"};
    tbl[7]  = '{1'b1, 32'h8, 32'h0000AB00, 4'h2, 32'h0,        "wr_baud_lane1"};
    tbl[8]  = '{1'b0, 32'h8, 32'h0,        4'h0, 32'h0000AB78, "baud_lane1"};
    tbl[9]  = '{1'b1, 32'hC, 32'hFFFFFFFF, 4'hF, 32'h0,        "wr_reserved"};
    tbl[10] = '{1'b0, 32'hC, 32'h0,        4'h0, 32'h00000000, "reserved_zero"};
    tbl[11] = '{1'b1, 32'h8, 32'h0,        4'h3, 32'h0,        "wr_baud_zero"};
    tbl[12] = '{1'b0, 32'h8, 32'h0,        4'h0, 32'h00000000, "baud_zero"};
    tbl[13] = '{1'b0, 32'h4, 32'h0,        4'h0, 32'h00000000, "status_idle"};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_read_data", read_data, 32'h0);
    check("rst_data_valid", {31'd0, data_valid}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Register table
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].wr) bus_write(tbl[i].addr, tbl[i].wdata, tbl[i].be);
      else           rd_chk(tbl[i].name, tbl[i].addr, tbl[i].exp);
    end

    // Single byte at 16 clk/bit
    send_byte(8'hA5, 1'b1, 1'b0, 16);
    rd_chk("a5_status", 32'h4, 32'h00000101);
    check("a5_irq", {31'd0, irq}, 32'd1);
    rd_rx("a5_data");
    rd_chk("a5_status_after", 32'h4, 32'h0);
    check("a5_irq_after", {31'd0, irq}, 32'd0);

    // Overrun: DEPTH+1 bytes without reading
    for (int i = 0; i < DEPTH + 1; i++) send_byte(8'(i), 1'b1, 1'b0, 16);
    rd_chk("ovr_status", 32'h4, 32'h00000807);
    check("ovr_irq", {31'd0, irq}, 32'd1);
    for (int i = 0; i < DEPTH + 1; i++) rd_rx("ovr_data");
    rd_chk("ovr_status_drained", 32'h4, 32'h00000004);
    bus_write(32'h4, 32'h4, 4'h1);
    rd_chk("ovr_cleared", 32'h4, 32'h0);

    // Framing error
    send_byte(8'h3C, 1'b0, 1'b0, 16);
    rd_chk("fe_status", 32'h4, 32'h00000008);
    check("fe_irq", {31'd0, irq}, 32'd1);
    bus_write(32'h4, 32'h8, 4'h1);
    rd_chk("fe_cleared", 32'h4, 32'h0);
    check("fe_irq_cleared", {31'd0, irq}, 32'd0);

    // Start-bit glitch, then confirm receiver still works
    @(negedge clk);
    hold_rx(1'b0, 4);
    hold_rx(1'b1, 40);
    rd_chk("glitch_status", 32'h4, 32'h0);
    check("glitch_irq", {31'd0, irq}, 32'd0);
    send_byte(8'h11, 1'b1, 1'b0, 16);
    rd_rx("post_glitch_data");

    // Slower baud: 64 clk/bit
    bus_write(32'h8, 32'h00000003, 4'h3);
    rd_chk("baud3", 32'h8, 32'h00000003);
    send_byte(8'h5A, 1'b1, 1'b0, 64);
    rd_chk("b3_status", 32'h4, 32'h00000101);
    rd_rx("b3_data");

`ifdef UART_RX_PARITY_EN
    send_byte(8'h07, 1'b1, 1'b1, 64);
    rd_chk("pe_status", 32'h4, 32'h00000010);
    rd_rx("pe_discard");
    bus_write(32'h4, 32'h10, 4'h1);
    rd_chk("pe_cleared", 32'h4, 32'h0);
    send_byte(8'h07, 1'b1, 1'b0, 64);
    rd_rx("par_ok_data");
`endif

    // Reset mid-frame: no partial byte, registers back to defaults
    @(negedge clk);
    hold_rx(1'b0, 100);
    rx = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hold_rx(1'b1, 20);
    rd_chk("midrst_status", 32'h4, 32'h0);
    rd_chk("midrst_baud", 32'h8, 32'h0000001A);
    check("midrst_irq", {31'd0, irq}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Overall time bound
  initial begin
    #5_000_000;
    $display("FAIL timeout: got no_finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/uart_rx_peripheral.md
# uart_rx_peripheral

Memory-mapped UART receiver that sits behind one `axi4_lite_slave` in the peripheral subsystem, complementing the existing transmit-only UART. It oversamples the serial `rx` line at 16x, deframes 8-bit characters, buffers them in a receive FIFO, and exposes data, status and baud divisor through the slave's peripheral-side write/read port. An interrupt output flags pending data or errors.

## Interface
- `DATA_WIDTH`, 32, peripheral data bus width
- `ADDR_WIDTH`, 32, peripheral address width; only bits [3:2] decoded
- `FIFO_DEPTH`, 8, receive FIFO entries (power of two, 2..64)
- `DEFAULT_DIV`, 26, reset value of BAUD_DIV (clocks per oversample tick minus 1)

- `clk` in 1 — single clock
- `rst` in 1 — asynchronous, active-high reset
- `mem_write` in 1 — write strobe from slave, one cycle per write
- `byte_en` in 4 — write byte enables
- `write_addr` in ADDR_WIDTH — write address
- `write_data` in DATA_WIDTH — write data
- `read_en` in 1 — read strobe, one cycle per read
- `read_addr` in ADDR_WIDTH — read address
- `read_data` out DATA_WIDTH — registered read data
- `data_valid` out 1 — read_data valid, feeds slave `data_valid`
- `rx` in 1 — asynchronous serial input, idle high
- `irq` out 1 — level interrupt

## Operation
- Register map (offset = addr[3:2]*4): 0x0 RXDATA (RO, read pops FIFO, data in [7:0]); 0x4 STATUS; 0x8 BAUD_DIV (RW, [15:0]); 0xC reserved (reads 0, writes ignored).
- STATUS: [0] not_empty, [1] full, [2] overrun (sticky, W1C), [3] frame_err (sticky, W1C), [4] parity_err (sticky, W1C; 0 when parity compiled out), [14:8] FIFO count.
- Writes honour byte_en; BAUD_DIV byte lanes 0-1 only; STATUS W1C uses lane 0.
- `rx` passes through 2-flop synchronizer before any use.
- Tick generator: counter reloads from BAUD_DIV; one tick every BAUD_DIV+1 clocks. Writing BAUD_DIV restarts the counter.
- RX FSM: IDLE -> START on synchronized rx falling to 0; START samples at tick 8: rx=1 -> IDLE (glitch), rx=0 -> DATA; DATA samples 8 bits LSB-first every 16 ticks; [PARITY]; STOP samples stop bit -> IDLE.
- Stop bit 0: set frame_err, discard byte, FSM waits for rx=1 before re-arming IDLE.
- Valid byte pushed on STOP sample. FIFO full at push: byte dropped, overrun set.
- Read of RXDATA when empty: returns 0, no pop, no error.
- `irq` = not_empty | overrun | frame_err | parity_err.

## Timing
- Reset: read_data=0, data_valid=0, irq=0, FIFO empty, sticky flags 0, BAUD_DIV=DEFAULT_DIV, FSM IDLE.
- Read latency 1: read_en in cycle N -> read_data and data_valid=1 in N+1; data_valid low otherwise. Pop takes effect at end of cycle N.
- Write takes effect end of the mem_write cycle; read of same register next cycle sees new value.
- Push and pop in same cycle: both performed, count unchanged; allowed when full (no overrun) and when empty-pop coincides with push (pop ignored, push stored).
- W1C in the same cycle the flag is set: set wins.
- Sample point: center of bit = 8 ticks after start edge + 16n; synchronizer adds 2 clocks fixed skew.
- FIFO pointers wrap modulo FIFO_DEPTH; count has log2(FIFO_DEPTH)+1 bits.
- Reset mid-frame aborts frame; no partial byte pushed.

## Configuration
- `UART_RX_PARITY_EN`: defined -> 8E1 frames; PARITY state samples a ninth bit, even parity checked; mismatch sets parity_err and discards byte. Undefined -> 8N1, no PARITY state, STATUS[4] reads 0.

## Test plan
- BAUD_DIV=0 (16 clk/bit), send 0xA5 8N1 -> STATUS=0x0101, irq=1; read 0x0 -> read_data=0x000000A5, data_valid 1 cycle later, STATUS then 0x0000, irq=0.
- Send FIFO_DEPTH+1 bytes 0x00..0x08 without reading -> STATUS full=1, overrun=1, count=8; eight reads return 0x00..0x07, ninth returns 0.
- Send 0x3C with stop bit 0 -> frame_err=1, count=0; write 0x8 to STATUS (byte_en=0001) -> frame_err=0, irq=0.
- 4-clock low glitch on rx with BAUD_DIV=0 -> no push, FSM back to IDLE, STATUS=0.
- Write BAUD_DIV=0x0003 with byte_en=0011, readback 0x00000003; send 0x5A at 64 clk/bit -> received 0x5A.
- With `UART_RX_PARITY_EN`: send 0x07 with parity bit 0 -> parity_err=1, byte discarded; with parity 1 -> 0x07 received.
